// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: instr/pc/data lanes, Tnew countdown, GPR write enable, bubble counter.
// Define PIPE_STAGE_EXC_EN to enable exception code / branch-delay tracking.

module pipe_stage_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bubble_i,
    input  logic              hold_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);
    logic [DATA_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (bubble_i)
            q_d = '0;
        else if (!hold_i)
            q_d = valid_i ? d_i : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

module pipe_stage_reg #(
    parameter int DATA_W      = 32,
    parameter int NUM_LANES   = 2,
    parameter int TNEW_W      = 2,
    parameter int DEC_ON_HOLD = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          int_exc_req,
    input  logic                          flush,
    input  logic                          stall,
    input  logic                          valid_in,
    input  logic [31:0]                   instr_in,
    input  logic [31:0]                   pc_in,
    input  logic [NUM_LANES*DATA_W-1:0]   data_in,
    input  logic                          reg_write_in,
    input  logic [TNEW_W-1:0]             tnew_in,
    input  logic [4:0]                    exc_code_in,
    input  logic                          exc_local_req,
    input  logic [4:0]                    exc_local_code,
    input  logic                          bd_in,
    output logic                          valid_out,
    output logic [31:0]                   instr_out,
    output logic [31:0]                   pc_out,
    output logic [NUM_LANES*DATA_W-1:0]   data_out,
    output logic                          reg_write_out,
    output logic [TNEW_W-1:0]             tnew_out,
    output logic [4:0]                    exc_code_out,
    output logic                          bd_out,
    output logic [15:0]                   bubble_cnt
);
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    logic bubble_ld;
    logic exc_taken;

    assign bubble_ld = int_exc_req | flush;

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc_q, pc_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic              rw_q, rw_d;
    logic [15:0]       bub_q, bub_d;

    // bubble > hold > capture; Tnew may keep draining while held
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        tnew_d  = tnew_q;
        rw_d    = rw_q;
        if (bubble_ld) begin
            valid_d = 1'b0;
            instr_d = '0;
            pc_d    = '0;
            tnew_d  = '0;
            rw_d    = 1'b0;
        end else if (stall) begin
            if (DEC_ON_HOLD != 0)
                tnew_d = sat_dec(tnew_q);
        end else begin
            valid_d = valid_in;
            instr_d = valid_in ? instr_in : '0;
            pc_d    = valid_in ? pc_in : '0;
            tnew_d  = valid_in ? sat_dec(tnew_in) : '0;
            rw_d    = reg_write_in & valid_in & ~exc_taken;
        end
    end

    always_comb begin
        bub_d = bub_q;
        if (!valid_q && bub_q != 16'hFFFF)
            bub_d = bub_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            tnew_q  <= '0;
            rw_q    <= 1'b0;
            bub_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            tnew_q  <= tnew_d;
            rw_q    <= rw_d;
            bub_q   <= bub_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            pipe_stage_lane #(.DATA_W(DATA_W)) u_lane (
                .clk      (clk),
                .reset    (reset),
                .bubble_i (bubble_ld),
                .hold_i   (stall),
                .valid_i  (valid_in),
                .d_i      (data_in[k*DATA_W +: DATA_W]),
                .q_o      (data_out[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

`ifdef PIPE_STAGE_EXC_EN
    logic [4:0] exc_sel;
    logic [4:0] exc_q, exc_d;
    logic       bd_q, bd_d;

    // an older upstream exception outranks one raised by the feeding stage
    always_comb begin
        exc_sel   = (exc_code_in != 5'd0) ? exc_code_in :
                    (exc_local_req ? exc_local_code : 5'd0);
        exc_taken = (exc_sel != 5'd0);
        exc_d     = exc_q;
        bd_d      = bd_q;
        if (bubble_ld) begin
            exc_d = '0;
            bd_d  = 1'b0;
        end else if (!stall) begin
            exc_d = exc_sel;
            bd_d  = bd_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_q <= '0;
            bd_q  <= 1'b0;
        end else begin
            exc_q <= exc_d;
            bd_q  <= bd_d;
        end
    end

    assign exc_code_out = exc_q;
    assign bd_out       = bd_q;
`else
    logic unused_exc;

    assign unused_exc   = ^{exc_code_in, exc_local_req, exc_local_code, bd_in};
    assign exc_taken    = 1'b0;
    assign exc_code_out = '0;
    assign bd_out       = 1'b0;
`endif

    assign valid_out     = valid_q;
    assign instr_out     = instr_q;
    assign pc_out        = pc_q;
    assign tnew_out      = tnew_q;
    assign reg_write_out = rw_q;
    assign bubble_cnt    = bub_q;
endmodule
